dom_and_vec: RTL and testbench
==============================

Name: dom_and_vec

Overview:
- Parametrised successor to the single-bit first-order masked AND.
- Computes y = a & b on WIDTH-bit vectors held as two Boolean shares (a = a0^a1, b = b0^b1). Uses a 2-stage domain-oriented-masking (DOM) pipeline.
- Has valid/ready flow control and explicit fresh-randomness handshaking. Sits between masked datapath stages of the cipher core.

Parameters:
- WIDTH, 8, number of independent masked AND bit-lanes.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand shares valid.
- in_ready  out  1  block can accept operands.
- a0  in  WIDTH  share 0 of a.
- a1  in  WIDTH  share 1 of a.
- b0  in  WIDTH  share 0 of b.
- b1  in  WIDTH  share 1 of b.
- rnd  in  WIDTH  fresh randomness, one bit per lane.
- rnd_valid  in  1  rnd holds unused fresh bits.
- rnd_ready  out  1  rnd consumed this cycle.
- out_valid  out  1  result shares valid.
- out_ready  in  1  downstream accepts result.
- y0  out  WIDTH  share 0 of a&b.
- y1  out  WIDTH  share 1 of a&b.

Behaviour:
- Reset: one clock; reset is synchronous and active-high. While rst=1 at a clock edge, all stage valids clear and all share/term registers go to 0. Outputs after reset: out_valid=0, y0=0, y1=0. rnd_ready=0 during reset.
- Accept condition: fire_in = in_valid & rnd_valid & in_ready. rnd_ready = fire_in. Randomness is never consumed without operands, and never reused.
- Stage 1 registers, per lane i:
  - i00 = a0&b0
  - i11 = a1&b1
  - c01 = (a0&b1) ^ rnd
  - c10 = (a1&b0) ^ rnd
  - Cross terms are registered before any compression (glitch barrier).
  - s1_valid is set on fire_in.
- Stage 2 registers: y0 = i00 ^ c01, y1 = i11 ^ c10. out_valid = s2_valid.
- Unmasked y0^y1 equals a&b bitwise.
- Latency: 2 cycles from fire_in to out_valid when there is no backpressure. Throughput 1/cycle.
- Flow control:
  - s2 advances when !s2_valid | out_ready.
  - s1 advances into s2 under the same condition.
  - in_ready = !s1_valid | s2 advancing.
  - Under stall, all registers hold and no combinational path mixes shares.
- out_ready may be held low indefinitely: y0/y1 stay stable while out_valid=1.
- Boundary cases:
  - in_valid=1, rnd_valid=0: no accept, s1 fills with a bubble.
  - Simultaneous output drain and input accept while full: both occur, no bubble.
  - rst mid-operation discards in-flight items; no partial output appears afterwards.
- Never output any unregistered combination of shares from different domains.

Optional Feature:
- Macro DOM_AND_REMASK_EN.
- Defined:
  - Adds port rnd_out (in, WIDTH).
  - Stage 2 computes y0 = i00^c01^rnd_out and y1 = i11^c10^rnd_out, giving output-share refresh for composition.
  - rnd_out is covered by the same rnd_valid/rnd_ready handshake, sampled at fire_in and carried in s1.
- Undefined: port absent, behaviour exactly as above.

Decomposition:
- Package dom_pkg: NSHARES=2 constant and typedef share_vec_t (logic [NSHARES-1:0][WIDTH-1:0]), shared by all masked gadgets.
- One natural sub-module: dom_pipe_stage, a generic valid/ready register stage of parametrised data width, instantiated twice.
- The lane logic stays inline.

Test Plan:
- Reset, then single op a=0xF0 (a0=0x5A, a1=0xAA), b=0x3C (b0=0x11, b1=0x2D), rnd=0x77 -> out_valid exactly 2 cycles later, y0^y1=0x30, rnd_ready pulsed once.
- 256 back-to-back ops with rnd_valid=1, out_ready=1 -> one result/cycle, all y0^y1==a&b, in_ready never drops.
- rnd_valid=0 for 5 cycles with in_valid=1 -> no acceptance, rnd_ready=0, out_valid stays 0; first result 2 cycles after rnd_valid rises.
- out_ready=0 for 10 cycles with 3 ops offered -> two accepted, in_ready=0, y0/y1 constant; release -> results in order, none lost.
- rst asserted while both stages valid -> next cycle out_valid=0, y0=y1=0, no stale output after release.
- With DOM_AND_REMASK_EN, a=b=0xFF, rnd_out=0xA5 -> y0^y1=0xFF, and y0 changes when only rnd_out changes.

Source files
------------

// File: rtl/dom_pkg.sv
// Shared constants and share-vector type for the masked (DOM) gadgets of the cipher core.
package dom_pkg;

    localparam int unsigned NSHARES   = 2;
    localparam int unsigned DOM_WIDTH = 8;

    typedef logic [NSHARES-1:0][DOM_WIDTH-1:0] share_vec_t;

endpackage : dom_pkg

// File: rtl/dom_pipe_stage.sv
// Generic valid/ready register stage: holds its word under backpressure, loads only valid data.
module dom_pipe_stage #(
    parameter int unsigned DW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [DW-1:0] data_i,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [DW-1:0] data_o
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q,  data_d;
    logic          advance;

    assign advance = !valid_q || ready_i;
    assign ready_o = advance;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
        valid_d = valid_q;
        data_d  = data_q;
        if (advance) begin
            valid_d = valid_i;
            if (valid_i) begin
                data_d = data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state is updated with non-blocking assignments only; the data word is reset too,
        // because zero shares after reset are part of the block's visible behaviour.
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule : dom_pipe_stage

// File: rtl/dom_and_vec.sv
// WIDTH-lane first-order DOM masked AND, two register stages with valid/ready and rnd handshake.
// Define DOM_AND_REMASK_EN to add rnd_out and refresh both output shares in stage 2.
module dom_and_vec
    import dom_pkg::*;
#(
    parameter int unsigned WIDTH = DOM_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] b1,
    input  logic [WIDTH-1:0] rnd,
`ifdef DOM_AND_REMASK_EN
    input  logic [WIDTH-1:0] rnd_out,
`endif
    input  logic             rnd_valid,
    output logic             rnd_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1
);

    typedef logic [NSHARES-1:0][WIDTH-1:0] lane_shares_t;

    typedef struct packed {
        logic [WIDTH-1:0] i00;
        logic [WIDTH-1:0] i11;
        logic [WIDTH-1:0] c01;
        logic [WIDTH-1:0] c10;
`ifdef DOM_AND_REMASK_EN
        logic [WIDTH-1:0] r_out;
`endif
    } s1_terms_t;

    s1_terms_t    s1_d, s1_q;
    lane_shares_t y_d, y_q;
    logic         s1_valid, s2_ready;

    // Cross-domain products are blinded by rnd and registered before they meet the inner terms.
    always_comb begin
        s1_d.i00 = a0 & b0;
        s1_d.i11 = a1 & b1;
        s1_d.c01 = (a0 & b1) ^ rnd;
        s1_d.c10 = (a1 & b0) ^ rnd;
`ifdef DOM_AND_REMASK_EN
        s1_d.r_out = rnd_out;
`endif
    end

    assign rnd_ready = in_valid && rnd_valid && in_ready && !rst;

    dom_pipe_stage #(
        .DW ($bits(s1_terms_t))
    ) u_stage1 (
        .clk_i   (clk),
        .rst_i   (rst),
        .valid_i (in_valid && rnd_valid),
        .ready_o (in_ready),
        .data_i  (s1_d),
        .valid_o (s1_valid),
        .ready_i (s2_ready),
        .data_o  (s1_q)
    );

    always_comb begin
`ifdef DOM_AND_REMASK_EN
        y_d[0] = s1_q.i00 ^ s1_q.c01 ^ s1_q.r_out;
        y_d[1] = s1_q.i11 ^ s1_q.c10 ^ s1_q.r_out;
`else
        y_d[0] = s1_q.i00 ^ s1_q.c01;
        y_d[1] = s1_q.i11 ^ s1_q.c10;
`endif
    end

    dom_pipe_stage #(
        .DW ($bits(lane_shares_t))
    ) u_stage2 (
        .clk_i   (clk),
        .rst_i   (rst),
        .valid_i (s1_valid),
        .ready_o (s2_ready),
        .data_i  (y_d),
        .valid_o (out_valid),
        .ready_i (out_ready),
        .data_o  (y_q)
    );

    assign y0 = y_q[0];
    assign y1 = y_q[1];

endmodule : dom_and_vec

// File: tb/tb_dom_and_vec.sv
// Randomised scoreboard bench for dom_and_vec; expected shares come from y_k = a_k & b ^ rnd (^ rnd_out).
module tb_dom_and_vec;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] y0;
        logic [W-1:0] y1;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready;
    logic [W-1:0] a0, a1, b0, b1, rnd;
`ifdef DOM_AND_REMASK_EN
    logic [W-1:0] rnd_out;
`endif
    logic         rnd_valid, rnd_ready;
    logic         out_valid, out_ready;
    logic [W-1:0] y0, y1;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_fire   = 0;
    int   n_out    = 0;
    bit   chk_stream_ready = 1'b0;
    exp_t exp_q[$];

    logic         s_out_valid, s_in_ready, s_rnd_ready;
    logic [W-1:0] s_y0, s_y1;

    dom_and_vec #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a0        (a0),
        .a1        (a1),
        .b0        (b0),
        .b1        (b1),
        .rnd       (rnd),
`ifdef DOM_AND_REMASK_EN
        .rnd_out   (rnd_out),
`endif
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y0        (y0),
        .y1        (y1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] sa0, sa1, sb0, sb1, r, ro);
        exp_t e;
        logic [W-1:0] b;
        b    = sb0 ^ sb1;
        e.y0 = (sa0 & b) ^ r ^ ro;
        e.y1 = (sa1 & b) ^ r ^ ro;
        return e;
    endfunction

    // One clock: sample and score at the falling edge, then return just after the rising edge.
    task automatic run_cycle();
        logic [W-1:0] ro;
        exp_t         e;
        @(negedge clk);
        s_out_valid = out_valid;
        s_in_ready  = in_ready;
        s_rnd_ready = rnd_ready;
        s_y0        = y0;
        s_y1        = y1;
        if (rst) begin
            check("rnd_ready_in_reset", rnd_ready, 1'b0);
        end else begin
            check("rnd_ready_handshake", rnd_ready, in_valid & rnd_valid & in_ready);
            if (chk_stream_ready) check("in_ready_stream", in_ready, 1'b1);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", out_valid, 1'b0);
                end else begin
                    check("y0_share", y0, exp_q[0].y0);
                    check("y1_share", y1, exp_q[0].y1);
                    check("y_unmasked", y0 ^ y1, exp_q[0].y0 ^ exp_q[0].y1);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        n_out++;
                    end
                end
            end
            if (rnd_ready) begin
`ifdef DOM_AND_REMASK_EN
                ro = rnd_out;
`else
                ro = '0;
`endif
                e = model(a0, a1, b0, b1, rnd, ro);
                exp_q.push_back(e);
                n_fire++;
            end
        end
        @(posedge clk);
        #1;
        if (rst) exp_q.delete();
    endtask

    task automatic drive_op(input logic [W-1:0] a, b);
        a0  = W'($urandom);
        a1  = a ^ a0;
        b0  = W'($urandom);
        b1  = b ^ b0;
        rnd = W'($urandom);
`ifdef DOM_AND_REMASK_EN
        rnd_out = W'($urandom);
`endif
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) run_cycle();
        check("drain_empty", exp_q.size(), 0);
        run_cycle();
        check("drain_out_valid", s_out_valid, 1'b0);
    endtask

    initial begin
        int f0, o0, idx;
        logic [W-1:0] ops_a[3], ops_b[3];

        rst = 1'b1; in_valid = 1'b1; rnd_valid = 1'b1; out_ready = 1'b1;
        drive_op(8'h12, 8'h34);
        run_cycle();
        run_cycle();

        // Post-reset state.
        rst = 1'b0; in_valid = 1'b0;
        run_cycle();
        check("reset_out_valid", s_out_valid, 1'b0);
        check("reset_y0", s_y0, 8'h00);
        check("reset_y1", s_y1, 8'h00);
        check("reset_in_ready", s_in_ready, 1'b1);

        // Single op with fixed shares, two-cycle latency.
        f0 = n_fire;
        a0 = 8'h5A; a1 = 8'hAA; b0 = 8'h11; b1 = 8'h2D; rnd = 8'h77;
`ifdef DOM_AND_REMASK_EN
        rnd_out = 8'h00;
`endif
        in_valid = 1'b1;
        run_cycle();
        check("single_rnd_ready", s_rnd_ready, 1'b1);
        in_valid = 1'b0;
        run_cycle();
        check("single_lat1_out_valid", s_out_valid, 1'b0);
        run_cycle();
        check("single_lat2_out_valid", s_out_valid, 1'b1);
        check("single_result", s_y0 ^ s_y1, 8'h30);
        check("single_rnd_pulses", n_fire - f0, 1);
        drain();

        // Back-to-back streaming.
        f0 = n_fire; o0 = n_out;
        chk_stream_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            drive_op(W'($urandom), W'($urandom));
            run_cycle();
        end
        chk_stream_ready = 1'b0;
        drain();
        check("stream_accepted", n_fire - f0, 256);
        check("stream_results", n_out - o0, 256);

        // Operands without randomness are not accepted.
        drive_op(8'hC3, 8'h5F);
        in_valid = 1'b1; rnd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            run_cycle();
            check("norand_rnd_ready", s_rnd_ready, 1'b0);
            check("norand_out_valid", s_out_valid, 1'b0);
        end
        rnd_valid = 1'b1;
        run_cycle();
        check("norand_fire", s_rnd_ready, 1'b1);
        in_valid = 1'b0;
        run_cycle();
        check("norand_lat1", s_out_valid, 1'b0);
        run_cycle();
        check("norand_lat2", s_out_valid, 1'b1);
        drain();

        // Backpressure: three ops offered, only two fit.
        for (int i = 0; i < 3; i++) begin
            ops_a[i] = W'($urandom);
            ops_b[i] = W'($urandom);
        end
        o0 = n_out; idx = 0; out_ready = 1'b0;
        drive_op(ops_a[0], ops_b[0]);
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            run_cycle();
            if (s_rnd_ready) begin
                idx++;
                if (idx < 3) drive_op(ops_a[idx], ops_b[idx]);
            end
        end
        check("stall_accepted", idx, 2);
        check("stall_in_ready", s_in_ready, 1'b0);
        check("stall_out_valid", s_out_valid, 1'b1);
        check("stall_no_output", n_out - o0, 0);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && idx < 3; c++) begin
            run_cycle();
            if (s_rnd_ready) idx++;
        end
        check("release_accepted", idx, 3);
        drain();
        check("release_results", n_out - o0, 3);

        // Reset with both stages full.
        out_ready = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            drive_op(W'($urandom), W'($urandom));
            run_cycle();
        end
        check("prereset_out_valid", s_out_valid, 1'b1);
        rst = 1'b1;
        run_cycle();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        run_cycle();
        check("midreset_out_valid", s_out_valid, 1'b0);
        check("midreset_y0", s_y0, 8'h00);
        check("midreset_y1", s_y1, 8'h00);
        for (int c = 0; c < 4; c++) begin
            run_cycle();
            check("postreset_no_stale", s_out_valid, 1'b0);
        end

`ifdef DOM_AND_REMASK_EN
        begin
            logic [W-1:0] y0_first;
            drive_op(8'hFF, 8'hFF);
            rnd_out = 8'hA5; in_valid = 1'b1;
            run_cycle();
            in_valid = 1'b0;
            run_cycle();
            run_cycle();
            check("remask_valid", s_out_valid, 1'b1);
            check("remask_result", s_y0 ^ s_y1, 8'hFF);
            y0_first = s_y0;
            drain();
            rnd_out = 8'h5A; in_valid = 1'b1;
            run_cycle();
            in_valid = 1'b0;
            run_cycle();
            run_cycle();
            check("remask_result2", s_y0 ^ s_y1, 8'hFF);
            check("remask_y0_delta", y0_first ^ s_y0, 8'hFF);
            drain();
        end
`endif

        // Random traffic with random backpressure and randomness gaps.
        for (int c = 0; c < 300; c++) begin
            drive_op(W'($urandom), W'($urandom));
            in_valid  = ($urandom_range(3) != 0);
            rnd_valid = ($urandom_range(3) != 0);
            out_ready = $urandom_range(1) == 1;
            run_cycle();
        end
        rnd_valid = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_dom_and_vec
